// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD encoder using shift-and-add-3, one input bit per clock.
// Registered digits feed a 4-digit 7-segment decoder; out-of-range values give 4'hF blanks.
module bin2bcd_seq #(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [3:0]       x0,
   output logic [3:0]       x1,
   output logic [3:0]       x2,
   output logic [3:0]       x3
);

   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t           state_q, state_d;
   logic [BIN_W-1:0] shift_q, shift_d;
   logic [15:0]      bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_flag_q, ovf_flag_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic [15:0]      digits_q, digits_d;

   // Add-3 correction per nibble before each shift keeps every nibble a legal BCD digit.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_flag_d = ovf_flag_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      digits_d   = digits_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               shift_d    = bin;
               bcd_d      = 16'h0000;
               cnt_d      = CNT_W'(BIN_W);
               ovf_flag_d = (32'(bin) > 32'd9999);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d   = {bcd_adj[14:0], shift_q[BIN_W-1]};
            shift_d = {shift_q[BIN_W-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
               state_d = FINISH;
         end
         FINISH: begin
            digits_d = ovf_flag_q ? 16'hFFFF : bcd_q;
            ovf_d    = ovf_flag_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: scratch registers are reset too, so an aborted conversion leaves nothing behind.
         state_q    <= IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_flag_q <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         digits_q   <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_flag_q <= ovf_flag_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         digits_q   <= digits_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign ovf  = ovf_q;
   assign x0   = digits_q[3:0];
   assign x1   = digits_q[7:4];
   assign x2   = digits_q[11:8];
   assign x3   = digits_q[15:12];

endmodule
